// File: rtl/prio_req_arbiter.sv
// Grant sequencer for 8 requesters that share one datapath.
// Supports fixed or round-robin priority, a hold limit, and one dead cycle between owners.
//
// state | meaning
// IDLE  | no owner; arbitrate every edge while en=0
// GRANT | owner holds the datapath; hold counter runs
// GAP   | one dead cycle after release (break-before-make); arbitrates like IDLE
module prio_req_arbiter #(
  parameter int N        = 8,
  parameter int IW       = 3,
  parameter int MAX_HOLD = 16,
  parameter int CW       = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          mode,
  input  logic [N-1:0]  req,
  input  logic [N-1:0]  mask,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          gnt_valid,
  output logic          timeout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          valid_q, valid_d;
  logic          timeout_q, timeout_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] ptr_q, ptr_d;

  logic [N-1:0]  elig;
  logic          win_found;
  logic [IW-1:0] win_idx;
  logic [IW-1:0] cand;
  logic          owner_ok;
  logic          hold_hit;

  // Step k of the search visits N-k (fixed) or ptr-k mod N (round-robin, ptr visited last).
  always_comb begin
    elig      = req & mask;
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= N; k++) begin
      cand = mode ? (ptr_q - IW'(k)) : IW'(N - k);
      if (!win_found && elig[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign owner_ok = req[idx_q] & mask[idx_q];
  assign hold_hit = (cnt_q == CW'(MAX_HOLD));

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    idx_d     = idx_q;
    valid_d   = valid_q;
    timeout_d = 1'b0;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    case (state_q)
      IDLE, GAP: begin
        if (!en && win_found) begin
          state_d = GRANT;
          gnt_d   = N'(1) << win_idx;
          idx_d   = win_idx;
          valid_d = 1'b1;
          cnt_d   = CW'(1);
        end else begin
          state_d = IDLE;
          gnt_d   = '0;
          valid_d = 1'b0;
        end
      end
      GRANT: begin
        if (en || !owner_ok || hold_hit) begin
          state_d   = GAP;
          gnt_d     = '0;
          valid_d   = 1'b0;
          // Only a hold-limit revocation is flagged; enable and request drops take precedence.
          timeout_d = !en && owner_ok;
          if (mode) ptr_d = idx_q;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      idx_q     <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
      ptr_q     <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      idx_q     <= idx_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = idx_q;
  assign gnt_valid = valid_q;
  assign timeout   = timeout_q;

endmodule

// File: doc/prio_req_arbiter.md
Name: prio_req_arbiter

Overview:
- Sequences a shared resource among 8 requesters.
- Uses a priority-encode search: either fixed priority (highest index wins) or round-robin rotating priority.
- Holds each grant until the owner releases it or a hold limit expires.
- Sits in front of the shared datapath; gnt/gnt_idx drive its select lines.

Parameters:
- N, 8, number of requesters; power of two, 2..16.
- IW, 3, grant index width; equals log2(N).
- MAX_HOLD, 16, maximum consecutive cycles one owner may hold a grant; range 1..2^CW-1.
- CW, 5, hold counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  active-low enable; 0 = arbitration enabled.
- mode  in  1  0 = fixed priority, 1 = round-robin.
- req  in  N  request vector, level-sensitive.
- mask  in  N  1 = requester allowed; 0 = request ignored.
- gnt  out  N  one-hot grant, registered.
- gnt_idx  out  IW  binary index of the owner; valid only when gnt_valid=1.
- gnt_valid  out  1  a grant is active.
- timeout  out  1  one-cycle pulse when a grant is revoked by the hold limit.

Behaviour:
- Reset (rst=1 at an edge):
  - gnt=0, gnt_idx=0, gnt_valid=0, timeout=0.
  - state=IDLE, hold counter=0, rr pointer ptr=0.
  - Reset has priority over every other event, including mid-grant.
- Eligible set: E = req & mask, considered only when en=0.
- Search order:
  - Fixed: index N-1 down to 0; first eligible index wins.
  - Round-robin: ptr-1, ptr-2, ..., wrapping past 0 to N-1, ending at ptr. Ptr itself is lowest priority.
- FSM states: IDLE, GRANT, GAP.
- IDLE:
  - If en=0 and E!=0, at the edge: go to GRANT; gnt=onehot(w), gnt_idx=w, gnt_valid=1, counter=1.
  - Otherwise stay in IDLE with outputs 0.
- Latency: a request sampled at edge k produces gnt visible after edge k, i.e. one clock.
- GRANT, evaluated at each edge in this priority:
  1. en=1 -> release.
  2. req[owner]=0 or mask[owner]=0 -> release.
  3. counter==MAX_HOLD -> release, and timeout=1 for the following cycle.
  4. Otherwise hold and increment counter.
  - Maximum grant length is therefore MAX_HOLD cycles.
- Release:
  - Go to GAP; gnt=0, gnt_valid=0; gnt_idx keeps its last value.
  - In round-robin mode, ptr := owner. The ptr update happens on every release cause, in RR mode only.
- GAP:
  - Exactly one dead cycle, which guarantees break-before-make on the datapath selects.
  - At the next edge, behaves as IDLE: it may grant immediately.
  - timeout clears.
- Fixed mode after timeout: the same owner may regain the grant after GAP if it is still the highest eligible requester. This is intentional; starvation is possible only in fixed mode.
- Mode change:
  - Sampled only at arbitration in IDLE/GAP; never alters a grant in progress.
  - ptr is retained across mode changes.
- Simultaneous owner release and new requests: release takes effect; the new winner is chosen in GAP, never in the same edge.
- Invariants:
  - gnt is always one-hot or zero.
  - gnt_valid == |gnt.
  - gnt_idx == encode(gnt) whenever gnt_valid=1.
- Mask behaviour: a masked bit never wins. Masking the owner releases it at the next edge like a deassert.
- en held high: no arbitration occurs; req changes are ignored.

Test Plan:
- Reset/idle: rst=1 for 2 cycles with req=8'hFF -> all outputs 0. Then rst=0, en=0, mode=0, mask=FF -> gnt=8'h80, gnt_idx=7 one cycle later.
- Fixed priority and release: req=8'b0010_0110 -> gnt_idx=5. Drop req[5] -> one GAP cycle with gnt=0, then gnt_idx=2.
- Round-robin rotation: mode=1, req=8'b1000_0001 held, MAX_HOLD=4 -> grants alternate 7,0,7,0. Each grant lasts 4 cycles, followed by a timeout pulse and one GAP cycle.
- Hold limit in fixed mode: mode=0, req=8'h80 held for 20 cycles, MAX_HOLD=4 -> pattern of 4 grant cycles and 1 gap cycle repeats. timeout pulses at cycles 5, 10, 15 after the first grant.
- Mask/enable: owner 6 granted; clear mask[6] -> release next edge. Then set en=1 with req=FF -> no grant until en=0.
- Reset mid-grant: owner 3 at counter=2, mode=1; assert rst -> outputs 0 next edge, ptr=0. After release of rst with req=8'b0000_1001, winner is 3.
